// File: rtl/div_pkg.sv
// Shared encodings and constants for the EX-stage divider sharing logic.
package div_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE  = 2'd0,
      DIV_BUSY  = 2'd1,
      DIV_DRAIN = 2'd2
   } div_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_L1   = 2'd1,
      OWN_L2   = 2'd2
   } div_owner_e;

   // Divide-by-zero result: quotient saturates to all-ones, remainder is the dividend.
   localparam logic [63:0] DBZ_QUOTIENT = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/div_result_slot.sv
// Per-line result holder: captures quotient/remainder, holds them until the line acks.
module div_result_slot #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_flush,
   input  logic         i_load,
   input  logic [W-1:0] i_quotient,
   input  logic [W-1:0] i_remainder,
   input  logic         i_ack,
   output logic         o_done,
   output logic [W-1:0] o_quotient,
   output logic [W-1:0] o_remainder
);

   // Flush beats load beats ack; a held result is never overwritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_done      <= 1'b0;
         o_quotient  <= '0;
         o_remainder <= '0;
      end else if (i_flush) begin
         o_done <= 1'b0;
      end else if (i_load && !o_done) begin
         o_done      <= 1'b1;
         o_quotient  <= i_quotient;
         o_remainder <= i_remainder;
      end else if (i_ack) begin
         o_done <= 1'b0;
      end
   end

endmodule

// File: rtl/div_share_ctrl.sv
// Arbitrates one iterative divider between two EX issue lines; line1 wins ties.
module div_share_ctrl
   import div_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         excep_flush_i,
   input  logic         line1_req_i,
   input  logic         line1_sign_i,
   input  logic [W-1:0] line1_dividend_i,
   input  logic [W-1:0] line1_divisor_i,
   input  logic         line1_ack_i,
   output logic         line1_done_o,
   output logic [W-1:0] line1_quotient_o,
   output logic [W-1:0] line1_remainder_o,
   input  logic         line2_req_i,
   input  logic         line2_sign_i,
   input  logic [W-1:0] line2_dividend_i,
   input  logic [W-1:0] line2_divisor_i,
   input  logic         line2_ack_i,
   output logic         line2_done_o,
   output logic [W-1:0] line2_quotient_o,
   output logic [W-1:0] line2_remainder_o,
   output logic         div_en_o,
   output logic         div_signed_o,
   output logic [W-1:0] div_dividend_o,
   output logic [W-1:0] div_divisor_o,
   output logic         div_clr_o,
   input  logic [W-1:0] quotient_i,
   input  logic [W-1:0] remainder_i,
   input  logic         finished_i,
   output logic         busy_o
);

   div_state_e r_state;
   div_owner_e r_owner;

   logic         w_elig1, w_elig2, w_gnt1, w_gnt2, w_dbz, w_fin;
   logic         w_gnt_sign;
   logic [W-1:0] w_gnt_dividend, w_gnt_divisor;
   logic         w_load1, w_load2;
   logic [W-1:0] w_res_q, w_res_r;

   // Arbitration and result-load steering; grants only in IDLE and never under flush.
   always_comb begin
      w_elig1        = line1_req_i & ~line1_done_o;
      w_elig2        = line2_req_i & ~line2_done_o;
      w_gnt1         = (r_state == DIV_IDLE) & ~excep_flush_i & w_elig1;
      w_gnt2         = (r_state == DIV_IDLE) & ~excep_flush_i & ~w_elig1 & w_elig2;
      w_gnt_sign     = w_gnt1 ? line1_sign_i     : line2_sign_i;
      w_gnt_dividend = w_gnt1 ? line1_dividend_i : line2_dividend_i;
      w_gnt_divisor  = w_gnt1 ? line1_divisor_i  : line2_divisor_i;
      w_dbz          = (w_gnt1 | w_gnt2) & (w_gnt_divisor == '0);
      w_fin          = (r_state == DIV_BUSY) & finished_i & ~excep_flush_i;
      w_load1        = (w_fin & (r_owner == OWN_L1)) | (w_dbz & w_gnt1);
      w_load2        = (w_fin & (r_owner == OWN_L2)) | (w_dbz & w_gnt2);
      w_res_q        = w_dbz ? W'(DBZ_QUOTIENT) : quotient_i;
      w_res_r        = w_dbz ? w_gnt_dividend   : remainder_i;
   end

   // Sequencer; divider inputs come only from the operand registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= DIV_IDLE;
         r_owner        <= OWN_NONE;
         div_en_o       <= 1'b0;
         div_signed_o   <= 1'b0;
         div_dividend_o <= '0;
         div_divisor_o  <= '0;
         div_clr_o      <= 1'b0;
         busy_o         <= 1'b0;
      end else begin
         div_clr_o <= 1'b0;
         if (excep_flush_i) begin
            r_state   <= DIV_DRAIN;
            r_owner   <= OWN_NONE;
            div_en_o  <= 1'b0;
            div_clr_o <= 1'b1;
            busy_o    <= 1'b1;
         end else begin
            case (r_state)
               DIV_IDLE: begin
                  if ((w_gnt1 | w_gnt2) && !w_dbz) begin
                     r_state        <= DIV_BUSY;
                     r_owner        <= w_gnt1 ? OWN_L1 : OWN_L2;
                     div_signed_o   <= w_gnt_sign;
                     div_dividend_o <= w_gnt_dividend;
                     div_divisor_o  <= w_gnt_divisor;
                     div_en_o       <= 1'b1;
                     busy_o         <= 1'b1;
                  end
               end
               DIV_BUSY: begin
                  if (finished_i) begin
                     r_state  <= DIV_IDLE;
                     div_en_o <= 1'b0;
                     busy_o   <= 1'b0;
                  end
               end
               DIV_DRAIN: begin
                  r_state <= DIV_IDLE;
                  busy_o  <= 1'b0;
               end
               default: begin
                  r_state  <= DIV_IDLE;
                  div_en_o <= 1'b0;
                  busy_o   <= 1'b0;
               end
            endcase
         end
      end
   end

   div_result_slot #(.W(W)) u_slot1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_flush     (excep_flush_i),
      .i_load      (w_load1),
      .i_quotient  (w_res_q),
      .i_remainder (w_res_r),
      .i_ack       (line1_ack_i),
      .o_done      (line1_done_o),
      .o_quotient  (line1_quotient_o),
      .o_remainder (line1_remainder_o)
   );

   div_result_slot #(.W(W)) u_slot2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_flush     (excep_flush_i),
      .i_load      (w_load2),
      .i_quotient  (w_res_q),
      .i_remainder (w_res_r),
      .i_ack       (line2_ack_i),
      .o_done      (line2_done_o),
      .o_quotient  (line2_quotient_o),
      .o_remainder (line2_remainder_o)
   );

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl; the bench plays the divider with hand-computed results.
module tb_div_share_ctrl;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         excep_flush_i;
   logic         line1_req_i, line1_sign_i, line1_ack_i;
   logic [W-1:0] line1_dividend_i, line1_divisor_i;
   logic         line2_req_i, line2_sign_i, line2_ack_i;
   logic [W-1:0] line2_dividend_i, line2_divisor_i;
   logic         line1_done_o, line2_done_o;
   logic [W-1:0] line1_quotient_o, line1_remainder_o;
   logic [W-1:0] line2_quotient_o, line2_remainder_o;
   logic         div_en_o, div_signed_o, div_clr_o, busy_o;
   logic [W-1:0] div_dividend_o, div_divisor_o;
   logic [W-1:0] quotient_i, remainder_i;
   logic         finished_i;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   div_share_ctrl #(.W(W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .excep_flush_i     (excep_flush_i),
      .line1_req_i       (line1_req_i),
      .line1_sign_i      (line1_sign_i),
      .line1_dividend_i  (line1_dividend_i),
      .line1_divisor_i   (line1_divisor_i),
      .line1_ack_i       (line1_ack_i),
      .line1_done_o      (line1_done_o),
      .line1_quotient_o  (line1_quotient_o),
      .line1_remainder_o (line1_remainder_o),
      .line2_req_i       (line2_req_i),
      .line2_sign_i      (line2_sign_i),
      .line2_dividend_i  (line2_dividend_i),
      .line2_divisor_i   (line2_divisor_i),
      .line2_ack_i       (line2_ack_i),
      .line2_done_o      (line2_done_o),
      .line2_quotient_o  (line2_quotient_o),
      .line2_remainder_o (line2_remainder_o),
      .div_en_o          (div_en_o),
      .div_signed_o      (div_signed_o),
      .div_dividend_o    (div_dividend_o),
      .div_divisor_o     (div_divisor_o),
      .div_clr_o         (div_clr_o),
      .quotient_i        (quotient_i),
      .remainder_i       (remainder_i),
      .finished_i        (finished_i),
      .busy_o            (busy_o)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic finish_div(input logic [31:0] q, input logic [31:0] r);
      quotient_i  = q;
      remainder_i = r;
      finished_i  = 1'b1;
      tick();
      finished_i  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; excep_flush_i = 1'b0; finished_i = 1'b0;
      quotient_i = '0; remainder_i = '0;
      line1_req_i = 1'b0; line1_sign_i = 1'b0; line1_ack_i = 1'b0;
      line1_dividend_i = '0; line1_divisor_i = '0;
      line2_req_i = 1'b0; line2_sign_i = 1'b0; line2_ack_i = 1'b0;
      line2_dividend_i = '0; line2_divisor_i = '0;
      #12;
      check_eq("rst_done1", 32'(line1_done_o), 32'd0);
      check_eq("rst_done2", 32'(line2_done_o), 32'd0);
      check_eq("rst_en",    32'(div_en_o), 32'd0);
      check_eq("rst_clr",   32'(div_clr_o), 32'd0);
      check_eq("rst_busy",  32'(busy_o), 32'd0);
      check_eq("rst_q1",    line1_quotient_o, 32'd0);
      check_eq("rst_dvd",   div_dividend_o, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: line1 alone, 100/7 unsigned
      line1_req_i = 1'b1; line1_sign_i = 1'b0;
      line1_dividend_i = 32'd100; line1_divisor_i = 32'd7;
      check_eq("t1_en_pre", 32'(div_en_o), 32'd0);
      tick();
      check_eq("t1_en",   32'(div_en_o), 32'd1);
      check_eq("t1_busy", 32'(busy_o), 32'd1);
      check_eq("t1_dvd",  div_dividend_o, 32'd100);
      check_eq("t1_dvs",  div_divisor_o, 32'd7);
      check_eq("t1_sgn",  32'(div_signed_o), 32'd0);
      line1_dividend_i = 32'd999;
      tick(); tick();
      check_eq("t1_dvd_stable", div_dividend_o, 32'd100);
      check_eq("t1_done_early", 32'(line1_done_o), 32'd0);
      finish_div(32'd14, 32'd2);
      check_eq("t1_done", 32'(line1_done_o), 32'd1);
      check_eq("t1_q",    line1_quotient_o, 32'd14);
      check_eq("t1_r",    line1_remainder_o, 32'd2);
      check_eq("t1_en_off", 32'(div_en_o), 32'd0);
      quotient_i = 32'hDEAD_BEEF;
      tick(); tick();
      check_eq("t1_hold_q",  line1_quotient_o, 32'd14);
      check_eq("t1_hold_en", 32'(div_en_o), 32'd0);
      line1_ack_i = 1'b1; line1_req_i = 1'b0;
      tick();
      line1_ack_i = 1'b0;
      check_eq("t1_ack", 32'(line1_done_o), 32'd0);

      // 2: both lines at once; line1 -9/2 signed, line2 9/4
      line1_req_i = 1'b1; line1_sign_i = 1'b1;
      line1_dividend_i = 32'hFFFF_FFF7; line1_divisor_i = 32'd2;
      line2_req_i = 1'b1; line2_sign_i = 1'b0;
      line2_dividend_i = 32'd9; line2_divisor_i = 32'd4;
      tick();
      check_eq("t2_dvd1", div_dividend_o, 32'hFFFF_FFF7);
      check_eq("t2_sgn1", 32'(div_signed_o), 32'd1);
      tick();
      finish_div(32'hFFFF_FFFC, 32'hFFFF_FFFF);
      check_eq("t2_done1",  32'(line1_done_o), 32'd1);
      check_eq("t2_q1",     line1_quotient_o, 32'hFFFF_FFFC);
      check_eq("t2_r1",     line1_remainder_o, 32'hFFFF_FFFF);
      check_eq("t2_done2a", 32'(line2_done_o), 32'd0);
      check_eq("t2_en_gap", 32'(div_en_o), 32'd0);
      tick();
      check_eq("t2_en2",  32'(div_en_o), 32'd1);
      check_eq("t2_dvd2", div_dividend_o, 32'd9);
      check_eq("t2_dvs2", div_divisor_o, 32'd4);
      check_eq("t2_sgn2", 32'(div_signed_o), 32'd0);
      tick();
      finish_div(32'd2, 32'd1);
      check_eq("t2_done2", 32'(line2_done_o), 32'd1);
      check_eq("t2_q2",    line2_quotient_o, 32'd2);
      check_eq("t2_r2",    line2_remainder_o, 32'd1);
      check_eq("t2_q1_held", line1_quotient_o, 32'hFFFF_FFFC);
      check_eq("t2_r1_held", line1_remainder_o, 32'hFFFF_FFFF);
      line1_req_i = 1'b0; line2_req_i = 1'b0;
      line1_ack_i = 1'b1; line2_ack_i = 1'b1;
      tick();
      line1_ack_i = 1'b0; line2_ack_i = 1'b0;
      check_eq("t2_ack1", 32'(line1_done_o), 32'd0);
      check_eq("t2_ack2", 32'(line2_done_o), 32'd0);

      // 3: line2 divide by zero
      line2_req_i = 1'b1; line2_sign_i = 1'b0;
      line2_dividend_i = 32'h1234; line2_divisor_i = 32'd0;
      tick();
      check_eq("t3_done", 32'(line2_done_o), 32'd1);
      check_eq("t3_q",    line2_quotient_o, 32'hFFFF_FFFF);
      check_eq("t3_r",    line2_remainder_o, 32'h1234);
      check_eq("t3_en",   32'(div_en_o), 32'd0);
      check_eq("t3_busy", 32'(busy_o), 32'd0);
      tick();
      check_eq("t3_en2",  32'(div_en_o), 32'd0);
      line2_req_i = 1'b0; line2_ack_i = 1'b1;
      tick();
      line2_ack_i = 1'b0;

      // 4: flush mid-BUSY with line2 holding a result, then a late finish
      line2_req_i = 1'b1; line2_dividend_i = 32'h55; line2_divisor_i = 32'd0;
      tick();
      check_eq("t4_done2_pre", 32'(line2_done_o), 32'd1);
      line1_req_i = 1'b1; line1_sign_i = 1'b0;
      line1_dividend_i = 32'd50; line1_divisor_i = 32'd5;
      tick();
      check_eq("t4_en", 32'(div_en_o), 32'd1);
      excep_flush_i = 1'b1; line1_req_i = 1'b0; line2_req_i = 1'b0;
      tick();
      excep_flush_i = 1'b0;
      check_eq("t4_clr",   32'(div_clr_o), 32'd1);
      check_eq("t4_done1", 32'(line1_done_o), 32'd0);
      check_eq("t4_done2", 32'(line2_done_o), 32'd0);
      check_eq("t4_en_off", 32'(div_en_o), 32'd0);
      check_eq("t4_drain_busy", 32'(busy_o), 32'd1);
      finish_div(32'd10, 32'd0);
      check_eq("t4_clr_once", 32'(div_clr_o), 32'd0);
      check_eq("t4_idle",     32'(busy_o), 32'd0);
      check_eq("t4_late1",    32'(line1_done_o), 32'd0);
      finish_div(32'd10, 32'd0);
      check_eq("t4_late1b", 32'(line1_done_o), 32'd0);
      check_eq("t4_late2b", 32'(line2_done_o), 32'd0);

      // 5: flush coincident with finished_i
      line1_req_i = 1'b1; line1_dividend_i = 32'd20; line1_divisor_i = 32'd4;
      tick();
      check_eq("t5_en", 32'(div_en_o), 32'd1);
      excep_flush_i = 1'b1; line1_req_i = 1'b0;
      finish_div(32'd5, 32'd0);
      excep_flush_i = 1'b0;
      check_eq("t5_done", 32'(line1_done_o), 32'd0);
      check_eq("t5_busy", 32'(busy_o), 32'd1);
      check_eq("t5_clr",  32'(div_clr_o), 32'd1);
      tick();
      check_eq("t5_idle", 32'(busy_o), 32'd0);

      // 6: ack and new request in the same cycle
      line1_req_i = 1'b1; line1_dividend_i = 32'd10; line1_divisor_i = 32'd5;
      tick();
      finish_div(32'd2, 32'd0);
      check_eq("t6_done_a", 32'(line1_done_o), 32'd1);
      line1_ack_i = 1'b1; line1_dividend_i = 32'd20; line1_divisor_i = 32'd3;
      tick();
      line1_ack_i = 1'b0;
      check_eq("t6_done_drop", 32'(line1_done_o), 32'd0);
      check_eq("t6_en_gap",    32'(div_en_o), 32'd0);
      tick();
      check_eq("t6_en",  32'(div_en_o), 32'd1);
      check_eq("t6_dvd", div_dividend_o, 32'd20);
      check_eq("t6_dvs", div_divisor_o, 32'd3);
      finish_div(32'd6, 32'd2);
      check_eq("t6_done", 32'(line1_done_o), 32'd1);
      check_eq("t6_q",    line1_quotient_o, 32'd6);
      check_eq("t6_r",    line1_remainder_o, 32'd2);
      line1_req_i = 1'b0; line1_ack_i = 1'b1;
      tick();
      line1_ack_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
